// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: opcodes, func3/func7
// codes, datapath select encodings, ALU operations and the FSM state enum.
package rv_ctrl_pkg;

  // Opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // func3 codes for ALU instructions
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // func3 codes for branches
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [6:0] FUNC7_SUB = 7'b0100000;

  // ALU operations
  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_AND  = 3'b010;
  localparam logic [2:0] ALUOP_OR   = 3'b011;
  localparam logic [2:0] ALUOP_SLT  = 3'b100;
  localparam logic [2:0] ALUOP_SLTU = 3'b101;
  localparam logic [2:0] ALUOP_XOR  = 3'b110;

  // Immediate types
  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_S = 3'b001;
  localparam logic [2:0] EXT_B = 3'b010;
  localparam logic [2:0] EXT_J = 3'b011;
  localparam logic [2:0] EXT_U = 3'b100;

  // Writeback sources
  localparam logic [1:0] REGSEL_ALU  = 2'b00;
  localparam logic [1:0] REGSEL_MDR  = 2'b01;
  localparam logic [1:0] REGSEL_IMM  = 2'b10;
  localparam logic [1:0] REGSEL_PC4  = 2'b11;

  // ALU operand sources
  localparam logic [1:0] ASEL_PC    = 2'b00;
  localparam logic [1:0] ASEL_OLDPC = 2'b01;
  localparam logic [1:0] ASEL_RS1   = 2'b10;
  localparam logic [1:0] BSEL_RS2   = 2'b00;
  localparam logic [1:0] BSEL_IMM   = 2'b01;
  localparam logic [1:0] BSEL_FOUR  = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_EXEC_R    = 4'd2,
    ST_EXEC_I    = 4'd3,
    ST_ALU_WB    = 4'd4,
    ST_MEM_ADDR  = 4'd5,
    ST_MEM_READ  = 4'd6,
    ST_MEM_WRITE = 4'd7,
    ST_MEM_WB    = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JAL       = 4'd10,
    ST_JALR      = 4'd11,
    ST_LUI       = 4'd12,
    ST_HALT      = 4'd13
  } state_t;

  // Which decode the ALU operation comes from
  typedef enum logic [1:0] {
    ALU_CLS_ADD = 2'd0,
    ALU_CLS_SUB = 2'd1,
    ALU_CLS_R   = 2'd2,
    ALU_CLS_I   = 2'd3
  } alu_cls_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from instruction class, func3 and func7.
// Shift func3 codes have no ALU encoding here and fall back to add.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [2:0] aluop
);

  // Map class plus function fields to an ALU operation
  always_comb begin
    aluop = ALUOP_ADD;
    case (cls)
      ALU_CLS_SUB: aluop = ALUOP_SUB;
      ALU_CLS_R, ALU_CLS_I: begin
        case (func3)
          F3_ADD:  aluop = (cls == ALU_CLS_R && func7 == FUNC7_SUB) ? ALUOP_SUB : ALUOP_ADD;
          F3_SLT:  aluop = ALUOP_SLT;
          F3_SLTU: aluop = ALUOP_SLTU;
          F3_XOR:  aluop = ALUOP_XOR;
          F3_OR:   aluop = ALUOP_OR;
          F3_AND:  aluop = ALUOP_AND;
          default: aluop = ALUOP_ADD;
        endcase
      end
      default: aluop = ALUOP_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM. Outputs are a Moore decode of the state,
// with op/func fields decoded in the execute states and mem_ready qualifying
// the fetch handshake. All outputs are forced low while rst is high.
// Optional build macro: ILLEGAL_OP_TRAP_EN -- unknown opcodes park the FSM in
// HALT with illegal=1 until reset; otherwise they are skipped like a NOP.
//
// state     | meaning
// ----------+--------------------------------------------------
// FETCH     | read instruction at PC, PC+4; wait for mem_ready
// DECODE    | precompute branch target into ALUOut, dispatch
// EXEC_R    | rs1 op rs2
// EXEC_I    | rs1 op imm
// ALU_WB    | write ALUOut to rd
// MEM_ADDR  | rs1 + imm effective address
// MEM_READ  | load from ALUOut; wait for mem_ready
// MEM_WRITE | store to ALUOut; wait for mem_ready
// MEM_WB    | write MDR to rd
// BRANCH    | compare rs1-rs2, conditionally take target
// JAL       | rd = oldPC+4, PC = target
// JALR      | rd = oldPC+4, PC = rs1+imm
// LUI       | rd = U-immediate
// HALT      | illegal opcode trap, left only by reset
module multicycle_controller
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       negetive,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsel,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       wereg,
  output logic [1:0] regsel,
  output logic [2:0] extend_func,
  output logic [1:0] alusela,
  output logic [1:0] aluselb,
  output logic [2:0] aluop,
  output logic       illegal
);

  state_t     state, state_next;
  alu_cls_t   cls;
  logic [2:0] dec_aluop;
  logic       taken;

  alu_decoder u_alu_decoder (
    .cls   (cls),
    .func3 (func3),
    .func7 (func7),
    .aluop (dec_aluop)
  );

  // Reset gating is combinational so a mid-cycle reset drops outputs at once
  assign aluop = rst ? ALUOP_ADD : dec_aluop;

  // Branch condition; unlisted func3 codes never branch
  always_comb begin
    taken = 1'b0;
    case (func3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      F3_BLT:  taken = negetive;
      F3_BGE:  taken = ~negetive;
      default: taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_next;
  end

  // Next-state and output decode
  always_comb begin
    state_next  = state;
    pcwrite     = 1'b0;
    adrsel      = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    wereg       = 1'b0;
    regsel      = REGSEL_ALU;
    extend_func = EXT_I;
    alusela     = ASEL_PC;
    aluselb     = BSEL_RS2;
    cls         = ALU_CLS_ADD;
    illegal     = 1'b0;

    case (state)
      ST_FETCH: begin
        memread = 1'b1;
        alusela = ASEL_PC;
        aluselb = BSEL_FOUR;
        if (mem_ready) begin
          irwrite    = 1'b1;
          pcwrite    = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alusela     = ASEL_OLDPC;
        aluselb     = BSEL_IMM;
        extend_func = EXT_B;
        case (op)
          OP_R:                state_next = ST_EXEC_R;
          OP_IMM:              state_next = ST_EXEC_I;
          OP_LOAD, OP_STORE:   state_next = ST_MEM_ADDR;
          OP_BRANCH:           state_next = ST_BRANCH;
          OP_JAL:              state_next = ST_JAL;
          OP_JALR:             state_next = ST_JALR;
          OP_LUI:              state_next = ST_LUI;
`ifdef ILLEGAL_OP_TRAP_EN
          default:             state_next = ST_HALT;
`else
          default:             state_next = ST_FETCH;
`endif
        endcase
      end
      ST_EXEC_R: begin
        alusela    = ASEL_RS1;
        aluselb    = BSEL_RS2;
        cls        = ALU_CLS_R;
        state_next = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        alusela     = ASEL_RS1;
        aluselb     = BSEL_IMM;
        extend_func = EXT_I;
        cls         = ALU_CLS_I;
        state_next  = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        wereg      = 1'b1;
        regsel     = REGSEL_ALU;
        state_next = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alusela     = ASEL_RS1;
        aluselb     = BSEL_IMM;
        extend_func = (op == OP_STORE) ? EXT_S : EXT_I;
        state_next  = (op == OP_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
      end
      ST_MEM_READ: begin
        memread = 1'b1;
        adrsel  = 1'b1;
        if (mem_ready) state_next = ST_MEM_WB;
      end
      ST_MEM_WRITE: begin
        memwrite = 1'b1;
        adrsel   = 1'b1;
        if (mem_ready) state_next = ST_FETCH;
      end
      ST_MEM_WB: begin
        wereg      = 1'b1;
        regsel     = REGSEL_MDR;
        state_next = ST_FETCH;
      end
      ST_BRANCH: begin
        alusela    = ASEL_RS1;
        aluselb    = BSEL_RS2;
        cls        = ALU_CLS_SUB;
        pcwrite    = taken;
        state_next = ST_FETCH;
      end
      ST_JAL: begin
        wereg       = 1'b1;
        regsel      = REGSEL_PC4;
        pcwrite     = 1'b1;
        extend_func = EXT_J;
        state_next  = ST_FETCH;
      end
      ST_JALR: begin
        wereg       = 1'b1;
        regsel      = REGSEL_PC4;
        alusela     = ASEL_RS1;
        aluselb     = BSEL_IMM;
        extend_func = EXT_I;
        pcwrite     = 1'b1;
        state_next  = ST_FETCH;
      end
      ST_LUI: begin
        wereg       = 1'b1;
        regsel      = REGSEL_IMM;
        extend_func = EXT_U;
        state_next  = ST_FETCH;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      ST_HALT: begin
        illegal    = 1'b1;
        state_next = ST_HALT;
      end
`endif
      default: state_next = ST_FETCH;
    endcase

    if (rst) begin
      {pcwrite, adrsel, memread, memwrite, irwrite, wereg} = 6'b0;
      regsel      = REGSEL_ALU;
      extend_func = EXT_I;
      alusela     = ASEL_PC;
      aluselb     = BSEL_RS2;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller. Inputs change on the
// falling edge; outputs are checked 1 ns later, before the next rising edge.
module tb_multicycle_controller;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] IM = 7'b0010011;
  localparam logic [6:0] JR = 7'b1100111;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] LU = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;
  localparam logic [6:0] SUB7 = 7'b0100000;

  typedef struct packed {
    logic       pcwrite, adrsel, memread, memwrite, irwrite, wereg;
    logic [1:0] regsel;
    logic [2:0] ext;
    logic [1:0] asel, bsel;
    logic [2:0] aluop;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z, n, rdy;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic zero = 1'b0, negetive = 1'b0, mem_ready = 1'b0;
  logic pcwrite, adrsel, memread, memwrite, irwrite, wereg, illegal;
  logic [1:0] regsel, alusela, aluselb;
  logic [2:0] extend_func, aluop;
  outs_t act;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .zero(zero), .negetive(negetive), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .adrsel(adrsel), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .wereg(wereg), .regsel(regsel), .extend_func(extend_func),
    .alusela(alusela), .aluselb(aluselb), .aluop(aluop), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign act = {pcwrite, adrsel, memread, memwrite, irwrite, wereg, regsel,
                extend_func, alusela, aluselb, aluop, illegal};

  function automatic outs_t mk(input logic pcw, adr, mr, mw, irw, we,
                               input logic [1:0] rs, input logic [2:0] ext,
                               input logic [1:0] a, b, input logic [2:0] alu,
                               input logic ill);
    return {pcw, adr, mr, mw, irw, we, rs, ext, a, b, alu, ill};
  endfunction

  outs_t E_FW, E_FG, E_DEC, E_WB, E_MR, E_MW, E_MWB, E_JAL, E_JALR, E_LUI, E_HALT;
  function automatic outs_t e_r(input logic [2:0] alu);  return mk(0,0,0,0,0,0,2'd0,3'd0,2'd2,2'd0,alu,0); endfunction
  function automatic outs_t e_i(input logic [2:0] alu);  return mk(0,0,0,0,0,0,2'd0,3'd0,2'd2,2'd1,alu,0); endfunction
  function automatic outs_t e_ma(input logic [2:0] ext); return mk(0,0,0,0,0,0,2'd0,ext,2'd2,2'd1,3'd0,0); endfunction
  function automatic outs_t e_br(input logic pc);        return mk(pc,0,0,0,0,0,2'd0,3'd0,2'd2,2'd0,3'd1,0); endfunction

  task automatic v(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                   input logic z, n, rdy, input outs_t e);
    vec_t t;
    t.op = o; t.f3 = f3; t.f7 = f7; t.z = z; t.n = n; t.rdy = rdy; t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input outs_t e);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %05h want %05h", name, act, e);
    end
  endtask

  task automatic step(input string name, input logic [6:0] o, input logic [2:0] f3,
                      input logic [6:0] f7, input logic z, n, rdy, input outs_t e);
    @(negedge clk);
    op = o; func3 = f3; func7 = f7; zero = z; negetive = n; mem_ready = rdy;
    #1;
    check(name, e);
  endtask

  initial begin
    E_FW   = mk(0,0,1,0,0,0,2'd0,3'd0,2'd0,2'd2,3'd0,0);
    E_FG   = mk(1,0,1,0,1,0,2'd0,3'd0,2'd0,2'd2,3'd0,0);
    E_DEC  = mk(0,0,0,0,0,0,2'd0,3'd2,2'd1,2'd1,3'd0,0);
    E_WB   = mk(0,0,0,0,0,1,2'd0,3'd0,2'd0,2'd0,3'd0,0);
    E_MR   = mk(0,1,1,0,0,0,2'd0,3'd0,2'd0,2'd0,3'd0,0);
    E_MW   = mk(0,1,0,1,0,0,2'd0,3'd0,2'd0,2'd0,3'd0,0);
    E_MWB  = mk(0,0,0,0,0,1,2'd1,3'd0,2'd0,2'd0,3'd0,0);
    E_JAL  = mk(1,0,0,0,0,1,2'd3,3'd3,2'd0,2'd0,3'd0,0);
    E_JALR = mk(1,0,0,0,0,1,2'd3,3'd0,2'd2,2'd1,3'd0,0);
    E_LUI  = mk(0,0,0,0,0,1,2'd2,3'd4,2'd0,2'd0,3'd0,0);
    E_HALT = mk(0,0,0,0,0,0,2'd0,3'd0,2'd0,2'd0,3'd0,1);

    // add x3,x1,x2
    v(R,3'b000,7'd0,0,0,1,E_FG); v(R,3'b000,7'd0,0,0,1,E_DEC);
    v(R,3'b000,7'd0,0,0,1,e_r(3'b000)); v(R,3'b000,7'd0,0,0,1,E_WB);
    // sub
    v(R,3'b000,SUB7,0,0,1,E_FG); v(R,3'b000,SUB7,0,0,1,E_DEC);
    v(R,3'b000,SUB7,0,0,1,e_r(3'b001)); v(R,3'b000,SUB7,0,0,1,E_WB);
    // and, slt, or (func7 bit on a non-add func3 is ignored)
    v(R,3'b111,7'd0,0,0,1,E_FG); v(R,3'b111,7'd0,0,0,1,E_DEC);
    v(R,3'b111,7'd0,0,0,1,e_r(3'b010)); v(R,3'b111,7'd0,0,0,1,E_WB);
    v(R,3'b010,7'd0,0,0,1,E_FG); v(R,3'b010,7'd0,0,0,1,E_DEC);
    v(R,3'b010,7'd0,0,0,1,e_r(3'b100)); v(R,3'b010,7'd0,0,0,1,E_WB);
    v(R,3'b110,SUB7,0,0,1,E_FG); v(R,3'b110,SUB7,0,0,1,E_DEC);
    v(R,3'b110,SUB7,0,0,1,e_r(3'b011)); v(R,3'b110,SUB7,0,0,1,E_WB);
    // addi with func7-like bits set must still add; fetch waits one cycle
    v(IM,3'b000,SUB7,0,0,0,E_FW); v(IM,3'b000,SUB7,0,0,1,E_FG);
    v(IM,3'b000,SUB7,0,0,1,E_DEC); v(IM,3'b000,SUB7,0,0,1,e_i(3'b000));
    v(IM,3'b000,SUB7,0,0,1,E_WB);
    // xori, sltiu
    v(IM,3'b100,7'd0,0,0,1,E_FG); v(IM,3'b100,7'd0,0,0,1,E_DEC);
    v(IM,3'b100,7'd0,0,0,1,e_i(3'b110)); v(IM,3'b100,7'd0,0,0,1,E_WB);
    v(IM,3'b011,7'd0,0,0,1,E_FG); v(IM,3'b011,7'd0,0,0,1,E_DEC);
    v(IM,3'b011,7'd0,0,0,1,e_i(3'b101)); v(IM,3'b011,7'd0,0,0,1,E_WB);
    // lw with two wait cycles in MEM_READ: 7 cycles
    v(LD,3'b010,7'd0,0,0,1,E_FG); v(LD,3'b010,7'd0,0,0,1,E_DEC);
    v(LD,3'b010,7'd0,0,0,1,e_ma(3'b000)); v(LD,3'b010,7'd0,0,0,0,E_MR);
    v(LD,3'b010,7'd0,0,0,0,E_MR); v(LD,3'b010,7'd0,0,0,1,E_MR);
    v(LD,3'b010,7'd0,0,0,1,E_MWB);
    // sw with one wait cycle
    v(ST,3'b010,7'd0,0,0,1,E_FG); v(ST,3'b010,7'd0,0,0,1,E_DEC);
    v(ST,3'b010,7'd0,0,0,1,e_ma(3'b001)); v(ST,3'b010,7'd0,0,0,0,E_MW);
    v(ST,3'b010,7'd0,0,0,1,E_MW);
    // branches
    v(BR,3'b000,7'd0,1,0,1,E_FG); v(BR,3'b000,7'd0,1,0,1,E_DEC); v(BR,3'b000,7'd0,1,0,1,e_br(1));
    v(BR,3'b000,7'd0,0,0,1,E_FG); v(BR,3'b000,7'd0,0,0,1,E_DEC); v(BR,3'b000,7'd0,0,0,1,e_br(0));
    v(BR,3'b001,7'd0,0,0,1,E_FG); v(BR,3'b001,7'd0,0,0,1,E_DEC); v(BR,3'b001,7'd0,0,0,1,e_br(1));
    v(BR,3'b100,7'd0,0,1,1,E_FG); v(BR,3'b100,7'd0,0,1,1,E_DEC); v(BR,3'b100,7'd0,0,1,1,e_br(1));
    v(BR,3'b101,7'd0,0,1,1,E_FG); v(BR,3'b101,7'd0,0,1,1,E_DEC); v(BR,3'b101,7'd0,0,1,1,e_br(0));
    v(BR,3'b010,7'd0,1,1,1,E_FG); v(BR,3'b010,7'd0,1,1,1,E_DEC); v(BR,3'b010,7'd0,1,1,1,e_br(0));
    // jal, jalr, lui
    v(JL,3'b000,7'd0,0,0,1,E_FG); v(JL,3'b000,7'd0,0,0,1,E_DEC); v(JL,3'b000,7'd0,0,0,1,E_JAL);
    v(JR,3'b000,7'd0,0,0,1,E_FG); v(JR,3'b000,7'd0,0,0,1,E_DEC); v(JR,3'b000,7'd0,0,0,1,E_JALR);
    v(LU,3'b000,7'd0,0,0,1,E_FG); v(LU,3'b000,7'd0,0,0,1,E_DEC); v(LU,3'b000,7'd0,0,0,1,E_LUI);

    // Reset: outputs forced low even though FETCH would assert memread
    repeat (3) @(posedge clk);
    @(negedge clk); mem_ready = 1'b1; #1;
    check("reset_outs", '0);
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
    check("first_fetch", E_FW);

    foreach (tbl[i])
      step($sformatf("vec%0d", i), tbl[i].op, tbl[i].f3, tbl[i].f7,
           tbl[i].z, tbl[i].n, tbl[i].rdy, tbl[i].exp);

    // Asynchronous reset while a store is waiting in MEM_WRITE
    step("sw_fetch", ST, 3'b010, 7'd0, 0, 0, 1, E_FG);
    step("sw_dec",   ST, 3'b010, 7'd0, 0, 0, 1, E_DEC);
    step("sw_addr",  ST, 3'b010, 7'd0, 0, 0, 1, e_ma(3'b001));
    step("sw_wait",  ST, 3'b010, 7'd0, 0, 0, 0, E_MW);
    #2 rst = 1'b1;
    #1 check("async_rst_drop", '0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
    check("post_rst_fetch", E_FW);
    step("post_rst_go", ST, 3'b010, 7'd0, 0, 0, 1, E_FG);
    step("post_rst_dec", ST, 3'b010, 7'd0, 0, 0, 1, E_DEC);
    step("post_rst_addr", ST, 3'b010, 7'd0, 0, 0, 1, e_ma(3'b001));
    step("post_rst_mw", ST, 3'b010, 7'd0, 0, 0, 1, E_MW);

    // Unknown opcode
    step("bad_fetch", BAD, 3'b000, 7'd0, 0, 0, 1, E_FG);
    step("bad_dec",   BAD, 3'b000, 7'd0, 0, 0, 1, E_DEC);
`ifdef ILLEGAL_OP_TRAP_EN
    for (int k = 0; k < 10; k++)
      step($sformatf("halt%0d", k), BAD, 3'b000, 7'd0, 0, 0, 1, E_HALT);
    @(negedge clk); rst = 1'b1; #1;
    check("halt_rst", '0);
`else
    step("bad_nop_fetch", BAD, 3'b000, 7'd0, 0, 0, 0, E_FW);
    step("bad_nop_go",    BAD, 3'b000, 7'd0, 0, 0, 1, E_FG);
    step("bad_nop_dec",   BAD, 3'b000, 7'd0, 0, 0, 1, E_DEC);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
